uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel UART receiver feeding the debug path of the MIPS top level.
//   Oversamples the RX line, frames start/data/parity/stop bits and delivers one byte per frame.
//   Drives the top-level i_rx_data/i_rx_parity/i_rx_done inputs, which the debug unit consumes.
//   Flags framing errors and, optionally, parity errors.
// PARAMETERS
//   DATA_WIDTH_UART    8           data bits per frame, sent LSB first
//   STOP_WIDTH_UART    1           stop bits expected (1 or 2)
//   PARITY_WIDTH_UART  1           0 = no parity bit, 1 = one parity bit (even parity)
//   CLK_FREQ           50_000_000  i_clock frequency in Hz
//   BAUD_RATE          19_200      line rate in bit/s
//   OVERSAMPLE         16          sample ticks per bit
// PORTS
//   i_clock        in   1                  system clock; everything is sampled on the rising edge
//   i_reset        in   1                  one clock; reset is asynchronous and active-low (0 = reset)
//   i_rx           in   1                  serial line, idles high; asynchronous to i_clock
//   o_rx_data      out  DATA_WIDTH_UART    last correctly framed byte
//   o_rx_parity    out  PARITY_WIDTH_UART  parity bit as received with o_rx_data
//   o_rx_done      out  1                  one-cycle pulse: o_rx_data/o_rx_parity updated
//   o_frame_err    out  1                  one-cycle pulse: stop bit sampled low
//   o_parity_err   out  1                  one-cycle pulse, coincident with o_rx_done: parity mismatch
// BEHAVIOUR
//   - Reset (i_reset=0, asynchronous): all outputs 0, FSM in IDLE, tick and bit counters 0, sync flops 1.
//   - i_rx passes through a 2-flop synchronizer (always present). The FSM sees the synced bit only.
//   - Tick: pulse every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks from a free-running counter.
//     DIV must be >= 2; the implementation adds an elaboration check that stops the build otherwise.
//   - FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. All sample counts below are in ticks.
//   - IDLE: synced rx=0 -> START with tick count cleared.
//   - START: at tick OVERSAMPLE/2-1 (mid-bit), rx=0 -> DATA; rx=1 -> IDLE (glitch, no output).
//   - DATA: every OVERSAMPLE ticks, shift rx into the MSB of the shift register (LSB-first line order).
//     After DATA_WIDTH_UART samples: -> PARITY if PARITY_WIDTH_UART=1, else -> STOP.
//   - PARITY: after OVERSAMPLE ticks, capture rx as the parity bit, then -> STOP.
//   - STOP: sample once per stop bit at OVERSAMPLE-tick spacing.
//     All stop bits high: pulse o_rx_done in the cycle after the last sample and load o_rx_data/o_rx_parity -> IDLE.
//     Any stop bit low: pulse o_frame_err, no o_rx_done, o_rx_data keeps its old value -> WAIT_IDLE.
//   - WAIT_IDLE: stay until synced rx=1, then -> IDLE (a break condition is never read as a new start).
//   - o_rx_data/o_rx_parity hold between frames. A new start is accepted in the first IDLE cycle,
//     so back-to-back frames with zero gap are received.
//   - Latency: o_rx_done rises about 2 sync cycles + (1.5 + DATA_WIDTH_UART + PARITY_WIDTH_UART
//     + STOP_WIDTH_UART - 1) bit times after the start edge.
//   - Reset asserted mid-frame aborts the frame immediately; no partial byte is ever output.
// CONFIGURATION
//   UART_RX_PARITY_CHECK_EN defined (and PARITY_WIDTH_UART=1):
//     o_parity_err = ^{data, parity} (even parity), pulsed together with o_rx_done.
//     The byte is still delivered when parity is wrong.
//   UART_RX_PARITY_CHECK_EN undefined: o_parity_err is tied to 0. The parity bit is still captured
//     on o_rx_parity for the debug unit to check.
// STRUCTURE
//   - Package uart_pkg holds:
//     - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
//     - the DIV / tick-count localparam functions;
//     - bit-counter width clog2(DATA_WIDTH_UART+1).
//     The future uart_transmitter shares this package.
//   - Sub-module uart_baud_tick (parameters CLK_FREQ, BAUD_RATE, OVERSAMPLE -> o_tick).
//     It is reused by the transmitter.
// TESTING (bench params CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 -> DIV=10, 1 bit = 160 clocks)
//   1. Frame 0xA5, parity 0, stop 1:
//      -> single o_rx_done pulse, o_rx_data=0xA5, o_rx_parity=0, both errors 0.
//   2. rx low for 30 clocks, then high:
//      -> no done or error pulse; FSM back in IDLE; o_rx_data unchanged.
//   3. Frame 0x3C with stop bit low:
//      -> o_frame_err pulse, no done, o_rx_data stays 0xA5.
//      Line held low 500 clocks, then high -> no spurious frame; next 0x12 is received.
//   4. Frame 0x01 with parity 0:
//      -> with macro: done plus o_parity_err=1 and o_rx_data=0x01.
//      -> without macro: done, o_parity_err=0, o_rx_parity=0.
//   5. Reset pulsed after the 4th data bit of 0xF0:
//      -> all outputs 0 while reset is low; a following 0x55 frame yields done with 0x55.
//   6. Frames 0x00 and 0xFF back-to-back, no idle gap:
//      -> two done pulses 1760 clocks apart (+/- 1 tick), data 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types and elaboration-time helpers (receiver and
//            transmitter use the same state encoding and tick arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // System clocks per oversample tick.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int last_tick(input int oversample);
        return oversample - 1;
    endfunction

    function automatic int bit_cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Free-running divider producing one oversample tick every DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int c_DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DIV - 1);

    generate
        if (c_DIV < 2) begin : g_div_check
            $error("uart_baud_tick: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else if (r_cnt == c_LAST) begin
            r_cnt  <= '0;
            o_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            o_tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : Oversampling UART receiver with framing and optional even-parity
//            checking (enabled by defining UART_RX_PARITY_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH_UART   = 8,
    parameter int STOP_WIDTH_UART   = 1,
    parameter int PARITY_WIDTH_UART = 1,
    parameter int CLK_FREQ          = 50_000_000,
    parameter int BAUD_RATE         = 19_200,
    parameter int OVERSAMPLE        = 16
) (
    input  logic                                                     i_clock,
    input  logic                                                     i_reset,
    input  logic                                                     i_rx,
    output logic [DATA_WIDTH_UART-1:0]                               o_rx_data,
    output logic [((PARITY_WIDTH_UART > 0) ? PARITY_WIDTH_UART : 1)-1:0] o_rx_parity,
    output logic                                                     o_rx_done,
    output logic                                                     o_frame_err,
    output logic                                                     o_parity_err
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = bit_cnt_width(DATA_WIDTH_UART);
    localparam logic [c_TICK_W-1:0] c_MID_TICK  = c_TICK_W'(mid_tick(OVERSAMPLE));
    localparam logic [c_TICK_W-1:0] c_LAST_TICK = c_TICK_W'(last_tick(OVERSAMPLE));
    localparam logic [c_BIT_W-1:0]  c_LAST_DATA = c_BIT_W'(DATA_WIDTH_UART - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_STOP = c_BIT_W'(STOP_WIDTH_UART - 1);

    logic                       w_tick;
    logic                       r_rx_meta, r_rx_sync;
    rx_state_t                  r_state, w_state_next;
    logic [c_TICK_W-1:0]        r_tick_cnt, w_tick_cnt_next;
    logic [c_BIT_W-1:0]         r_bit_cnt, w_bit_cnt_next;
    logic [DATA_WIDTH_UART-1:0] r_shift, w_shift_next;
    logic                       r_parity_bit, w_parity_bit_next;
    logic                       r_stop_ok, w_stop_ok_next;
    logic                       w_done, w_frame_err, w_parity_err;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity_bit <= 1'b0;
            r_stop_ok    <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_tick_cnt   <= w_tick_cnt_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_parity_bit <= w_parity_bit_next;
            r_stop_ok    <= w_stop_ok_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_tick_cnt_next   = r_tick_cnt;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_parity_bit_next = r_parity_bit;
        w_stop_ok_next    = r_stop_ok;
        w_done            = 1'b0;
        w_frame_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_sync) begin
                    w_state_next    = START;
                    w_tick_cnt_next = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_MID_TICK) begin
                        w_tick_cnt_next = '0;
                        w_bit_cnt_next  = '0;
                        w_state_next    = r_rx_sync ? IDLE : DATA;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_LAST_TICK) begin
                        w_tick_cnt_next = '0;
                        // Line order is LSB first, so shifting in from the top lands bit 0 at the LSB.
                        w_shift_next    = {r_rx_sync, r_shift[DATA_WIDTH_UART-1:1]};
                        if (r_bit_cnt == c_LAST_DATA) begin
                            w_bit_cnt_next = '0;
                            w_stop_ok_next = 1'b1;
                            w_state_next   = (PARITY_WIDTH_UART == 1) ? PARITY : STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_LAST_TICK) begin
                        w_tick_cnt_next   = '0;
                        w_parity_bit_next = r_rx_sync;
                        w_state_next      = STOP;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == c_LAST_TICK) begin
                        w_tick_cnt_next = '0;
                        w_stop_ok_next  = r_stop_ok & r_rx_sync;
                        if (r_bit_cnt == c_LAST_STOP) begin
                            w_bit_cnt_next = '0;
                            if (r_stop_ok && r_rx_sync) begin
                                w_done       = 1'b1;
                                w_state_next = IDLE;
                            end else begin
                                w_frame_err  = 1'b1;
                                w_state_next = WAIT_IDLE;
                            end
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low (break) line must return high before a new start is armed.
                if (r_rx_sync) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_CHECK_EN
    assign w_parity_err = w_done && (PARITY_WIDTH_UART == 1) && (^{r_shift, r_parity_bit});
`else
    assign w_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_rx_data    <= '0;
            o_rx_parity  <= '0;
            o_rx_done    <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_rx_done    <= w_done;
            o_frame_err  <= w_frame_err;
            o_parity_err <= w_parity_err;
            if (w_done) begin
                o_rx_data   <= r_shift;
                o_rx_parity <= r_parity_bit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver (scoreboarded frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic [0:0] rx_parity;
    logic       rx_done, frame_err, parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int frame_cnt = 0;
    int done_cyc = 0;
    int prev_done_cyc = 0;
    int start_cyc = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       pe;
    } exp_t;
    exp_t sb[$];

    uart_receiver #(
        .DATA_WIDTH_UART   (8),
        .STOP_WIDTH_UART   (1),
        .PARITY_WIDTH_UART (1),
        .CLK_FREQ          (1_600_000),
        .BAUD_RATE         (10_000),
        .OVERSAMPLE        (16)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_rx         (rx),
        .o_rx_data    (rx_data),
        .o_rx_parity  (rx_parity),
        .o_rx_done    (rx_done),
        .o_frame_err  (frame_err),
        .o_parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every done pulse is matched against the oldest pushed frame.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt      = done_cnt + 1;
            prev_done_cyc = done_cyc;
            done_cyc      = cyc;
            checks        = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected_done: got data 0x%02h, expected no frame", rx_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rx_data !== e.d) begin
                    errors = errors + 1;
                    $display("FAIL sb_data: got 0x%02h, expected 0x%02h", rx_data, e.d);
                end
                checks = checks + 1;
                if (rx_parity !== e.p) begin
                    errors = errors + 1;
                    $display("FAIL sb_parity: got %0b, expected %0b", rx_parity, e.p);
                end
                checks = checks + 1;
                if (parity_err !== e.pe) begin
                    errors = errors + 1;
                    $display("FAIL sb_parity_err: got %0b, expected %0b", parity_err, e.pe);
                end
            end
        end else if (parity_err) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL parity_err_alone: got 1 without done, expected 0");
        end
        if (frame_err) frame_cnt = frame_cnt + 1;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic exp_perr(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_CHECK_EN
        return ^{d, p};
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic push_and_send(input logic [7:0] d, input logic p);
        sb.push_back({d, p, exp_perr(d, p)});
        send_frame(d, p, 1'b1);
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks = checks + 1;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got 0x%02h, expected 0x00", rx_data); end
        checks = checks + 1;
        if ({rx_parity, rx_done, frame_err, parity_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %04b, expected 0000", {rx_parity, rx_done, frame_err, parity_err});
        end
        checks = checks + 1;
        if (dut.r_state !== uart_pkg::IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected 0", dut.r_state); end
        @(posedge clk);
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    task automatic test_basic_frame;
        int d0 = done_cnt;
        int f0 = frame_cnt;
        int lat;
        push_and_send(8'hA5, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        lat = done_cyc - start_cyc;
        checks = checks + 1;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d, expected %0d", done_cnt - d0, 1); end
        checks = checks + 1;
        if (frame_cnt !== f0) begin errors++; $display("FAIL basic_frame_err: got %0d pulses, expected 0", frame_cnt - f0); end
        checks = checks + 1;
        if (lat < 1664 || lat > 1704) begin errors++; $display("FAIL basic_latency: got %0d clocks, expected 1664..1704", lat); end
        checks = checks + 1;
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_hold: got 0x%02h, expected 0xA5", rx_data); end
    endtask

    task automatic test_glitch;
        int d0 = done_cnt;
        int f0 = frame_cnt;
        rx = 1'b0;
        repeat (30) @(posedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        checks = checks + 1;
        if (done_cnt !== d0 || frame_cnt !== f0) begin
            errors++;
            $display("FAIL glitch_pulses: got %0d done %0d frame_err, expected 0 0", done_cnt - d0, frame_cnt - f0);
        end
        checks = checks + 1;
        if (dut.r_state !== uart_pkg::IDLE) begin errors++; $display("FAIL glitch_state: got %0d, expected 0", dut.r_state); end
        checks = checks + 1;
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL glitch_data: got 0x%02h, expected 0xA5", rx_data); end
    endtask

    task automatic test_frame_error;
        int d0 = done_cnt;
        int f0 = frame_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (500) @(posedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks = checks + 1;
        if (frame_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_count: got %0d, expected 1", frame_cnt - f0); end
        checks = checks + 1;
        if (done_cnt !== d0) begin errors++; $display("FAIL ferr_no_done: got %0d done, expected 0", done_cnt - d0); end
        checks = checks + 1;
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got 0x%02h, expected 0xA5", rx_data); end
        push_and_send(8'h12, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        checks = checks + 1;
        if (done_cnt !== d0 + 1 || frame_cnt !== f0 + 1) begin
            errors++;
            $display("FAIL ferr_recover: got %0d done %0d frame_err, expected 1 1", done_cnt - d0, frame_cnt - f0);
        end
    endtask

    task automatic test_parity;
        int d0 = done_cnt;
        push_and_send(8'h01, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        checks = checks + 1;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL parity_done: got %0d, expected 1", done_cnt - d0); end
        checks = checks + 1;
        if (rx_data !== 8'h01 || rx_parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_hold: got 0x%02h/%0b, expected 0x01/0", rx_data, rx_parity);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0 = done_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if ({rx_data, rx_parity, rx_done, frame_err, parity_err} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got data 0x%02h flags %04b, expected 0x00 0000",
                     rx_data, {rx_parity, rx_done, frame_err, parity_err});
        end
        repeat (5) @(negedge clk);
        checks = checks + 1;
        if (rx_data !== 8'h00 || rx_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hold: got 0x%02h done %0b, expected 0x00 0", rx_data, rx_done);
        end
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        push_and_send(8'h55, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        checks = checks + 1;
        if (done_cnt !== d0 + 1 || rx_data !== 8'h55) begin
            errors++;
            $display("FAIL midreset_next: got %0d done data 0x%02h, expected 1 0x55", done_cnt - d0, rx_data);
        end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt;
        int gap;
        push_and_send(8'h00, 1'b0);
        push_and_send(8'hFF, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        gap = done_cyc - prev_done_cyc;
        checks = checks + 1;
        if (done_cnt !== d0 + 2) begin errors++; $display("FAIL b2b_count: got %0d, expected 2", done_cnt - d0); end
        checks = checks + 1;
        if (gap < 1750 || gap > 1770) begin errors++; $display("FAIL b2b_spacing: got %0d clocks, expected 1750..1770", gap); end
        checks = checks + 1;
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_last: got 0x%02h, expected 0xFF", rx_data); end
        checks = checks + 1;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_error();
        test_parity();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
